// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-9 streaming demultiplexer.
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int NOUT = 9;
  localparam int SELW = 4;
  localparam int ERR_CNT_W = 8;
  localparam logic [SELW-1:0] BCAST_SEL = 4'hF;

  typedef enum logic {
    IDLE,
    BCAST_WAIT
  } state_t;

  typedef logic [SELW-1:0] lane_idx_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One-deep output lane register: a load always wins over a consumer pop.
module demux_lane_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to9_stream.sv
// Streaming 1-to-9 demux with broadcast (sel 15) and illegal-select drop.
// Build option: define DEMUX_ERR_CNT_EN to implement the saturating err_count.
module demux1to9_stream
  import demux_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NOUT*WIDTH-1:0] out_data,
  output logic [NOUT-1:0]       out_valid,
  input  logic [NOUT-1:0]       out_ready,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count
);

  state_t          state_q, state_d;
  logic [NOUT-1:0] pending_q, pending_d;
  logic [NOUT-1:0] can_load, sel_hit, load;
  logic [WIDTH-1:0] bcast_buf, lane_din;
  logic            sel_bcast, sel_illegal, illegal_acc, bcast_capture;

  assign can_load = ~out_valid | out_ready;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NOUT; k++) sel_hit[k] = (in_sel == lane_idx_t'(k));
  end

  assign sel_bcast   = (in_sel == BCAST_SEL);
  assign sel_illegal = ~(|sel_hit) & ~sel_bcast;

  // Input acceptance, lane load selection and next state
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    load          = '0;
    lane_din      = in_data;
    in_ready      = 1'b0;
    illegal_acc   = 1'b0;
    bcast_capture = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (sel_bcast || sel_illegal) in_ready = 1'b1;
          else                          in_ready = |(sel_hit & can_load);
          if (in_valid && in_ready) begin
            if (sel_bcast) begin
              load = can_load;
              if (!(&can_load)) begin
                bcast_capture = 1'b1;
                pending_d     = ~can_load;
                state_d       = BCAST_WAIT;
              end
            end else if (sel_illegal) begin
              illegal_acc = 1'b1;
            end else begin
              load = sel_hit;
            end
          end
        end
        BCAST_WAIT: begin
          lane_din  = bcast_buf;
          load      = pending_q & can_load;
          pending_d = pending_q & ~can_load;
          if (pending_d == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      err_pulse <= illegal_acc;
    end
  end

  // Broadcast word is only read while pending lanes remain, so it needs no reset
  always_ff @(posedge clk) begin
    if (bcast_capture) bcast_buf <= in_data;
  end

`ifdef DEMUX_ERR_CNT_EN
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)            err_count <= '0;
    else if (illegal_acc) err_count <= sat_inc(err_count);
  end
`else
  assign err_count = '0;
`endif

  // Output lane registers
  for (genvar k = 0; k < NOUT; k++) begin : g_lane
    demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .din   (lane_din),
      .dout  (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k]),
      .ready (out_ready[k])
    );
  end

endmodule

// File: tb/tb_demux1to9_stream.sv
// Directed bench for demux1to9_stream: vector table plus hand-written multi-cycle sequences.
module tb_demux1to9_stream;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  in_data;
  logic [3:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [143:0] out_data;
  logic [8:0]   out_valid;
  logic [8:0]   out_ready;
  logic         err_pulse;
  logic [7:0]   err_count;

  int total = 0;
  int bad = 0;
  int exp_errs = 0;

  demux1to9_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic        vld;
    logic [8:0]  ordy;
    logic        rdy;
    logic [8:0]  ov;
    int          lane;
    logic [15:0] ld;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  function automatic logic [15:0] lane(input int k);
    return out_data[k*16 +: 16];
  endfunction

  function automatic logic [7:0] exp_cnt();
`ifdef DEMUX_ERR_CNT_EN
    return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    vecs[0] = '{4'd3,  16'h1234, 1'b1, 9'h1FF, 1'b1, 9'h008, 3, 16'h1234, 1'b0};
    vecs[1] = '{4'd0,  16'h0001, 1'b1, 9'h1FF, 1'b1, 9'h001, 0, 16'h0001, 1'b0};
    vecs[2] = '{4'd8,  16'h8888, 1'b1, 9'h1FF, 1'b1, 9'h100, 8, 16'h8888, 1'b0};
    vecs[3] = '{4'd3,  16'h3333, 1'b0, 9'h1FF, 1'b1, 9'h000, 8, 16'h8888, 1'b0};
    vecs[4] = '{4'd15, 16'hBEEF, 1'b1, 9'h1FF, 1'b1, 9'h1FF, 4, 16'hBEEF, 1'b0};
    vecs[5] = '{4'd15, 16'h5A5A, 1'b0, 9'h000, 1'b1, 9'h1FF, 0, 16'hBEEF, 1'b0};
    vecs[6] = '{4'd5,  16'h1111, 1'b1, 9'h000, 1'b0, 9'h1FF, 5, 16'hBEEF, 1'b0};
    vecs[7] = '{4'd5,  16'h2222, 1'b1, 9'h020, 1'b1, 9'h1FF, 5, 16'h2222, 1'b0};
    vecs[8] = '{4'd9,  16'h9999, 1'b1, 9'h000, 1'b1, 9'h1FF, 5, 16'h2222, 1'b1};

    reset = 1'b1; in_data = '0; in_sel = 4'd15; in_valid = 1'b0; out_ready = 9'h1FF;
    tick(); tick();
    chk("reset_ov", out_valid, 9'h000);
    chk("reset_data", out_data, '0);
    chk("reset_err", err_pulse, 1'b0);
    chk("reset_cnt", err_count, 8'h00);
    chk("reset_rdy", in_ready, 1'b0);
    reset = 1'b0;
    #1 chk("post_reset_rdy", in_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      in_sel = vecs[i].sel; in_data = vecs[i].data; in_valid = vecs[i].vld; out_ready = vecs[i].ordy;
      #1 chk($sformatf("vec%0d_rdy", i), in_ready, vecs[i].rdy);
      if (vecs[i].vld && vecs[i].rdy && vecs[i].sel >= 4'd9 && vecs[i].sel <= 4'd14) exp_errs++;
      tick();
      chk($sformatf("vec%0d_ov", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d_lane", i), lane(vecs[i].lane), vecs[i].ld);
      chk($sformatf("vec%0d_err", i), err_pulse, vecs[i].err);
    end
    chk("vec_cnt", err_count, exp_cnt());
    in_valid = 1'b0; out_ready = 9'h1FF;
    tick();
    chk("drain_ov", out_valid, 9'h000);
    chk("drain_err", err_pulse, 1'b0);

    // backpressure on lane 5
    out_ready = 9'h1DF; in_sel = 4'd5; in_data = 16'hAAAA; in_valid = 1'b1;
    #1 chk("bp_rdy_a", in_ready, 1'b1);
    tick();
    chk("bp_ov_a", out_valid, 9'h020);
    chk("bp_lane_a", lane(5), 16'hAAAA);
    in_data = 16'hBBBB;
    #1 chk("bp_rdy_b0", in_ready, 1'b0);
    tick();
    chk("bp_rdy_b1", in_ready, 1'b0);
    chk("bp_lane_hold", lane(5), 16'hAAAA);
    out_ready = 9'h1FF;
    #1 chk("bp_rdy_b2", in_ready, 1'b1);
    tick();
    chk("bp_ov_b", out_valid, 9'h020);
    chk("bp_lane_b", lane(5), 16'hBBBB);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 9'h000);

    // illegal selects back to back
    foreach (vecs[i]) begin end
    for (int i = 0; i < 3; i++) begin
      in_sel = (i == 0) ? 4'd9 : (i == 1) ? 4'd12 : 4'd14;
      in_data = 16'hE000 + 16'(i); in_valid = 1'b1;
      #1 chk($sformatf("ill%0d_rdy", i), in_ready, 1'b1);
      exp_errs++;
      tick();
      chk($sformatf("ill%0d_err", i), err_pulse, 1'b1);
      chk($sformatf("ill%0d_ov", i), out_valid, 9'h000);
    end
    in_valid = 1'b0;
    tick();
    chk("ill_err_end", err_pulse, 1'b0);
    chk("ill_cnt", err_count, exp_cnt());

    // partial broadcast with lanes 2 and 7 stalled
    in_sel = 4'd2; in_data = 16'h0202; in_valid = 1'b1; out_ready = 9'h1FF;
    tick();
    in_sel = 4'd7; in_data = 16'h0707; out_ready = 9'h17B;
    tick();
    chk("bc_pre_ov", out_valid, 9'h084);
    in_sel = 4'd15; in_data = 16'hCAFE;
    #1 chk("bc_rdy0", in_ready, 1'b1);
    tick();
    chk("bc_ov1", out_valid, 9'h1FF);
    chk("bc_lane0", lane(0), 16'hCAFE);
    chk("bc_lane2_old", lane(2), 16'h0202);
    chk("bc_lane7_old", lane(7), 16'h0707);
    in_data = 16'hDEAD;
    #1 chk("bc_rdy1", in_ready, 1'b0);
    out_ready = 9'h17F;
    tick();
    chk("bc_ov2", out_valid, 9'h084);
    chk("bc_lane2", lane(2), 16'hCAFE);
    chk("bc_rdy2", in_ready, 1'b0);
    out_ready = 9'h1FF;
    tick();
    chk("bc_ov3", out_valid, 9'h080);
    chk("bc_lane7", lane(7), 16'hCAFE);
    chk("bc_rdy3", in_ready, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("bc_ov4", out_valid, 9'h000);
    chk("bc_lane0_keep", lane(0), 16'hCAFE);

    // reset while a broadcast is pending on lane 4
    in_sel = 4'd4; in_data = 16'h0404; in_valid = 1'b1;
    tick();
    out_ready = 9'h1EF; in_sel = 4'd15; in_data = 16'h5555;
    tick();
    chk("rb_ov", out_valid, 9'h1FF);
    chk("rb_rdy_wait", in_ready, 1'b0);
    in_valid = 1'b0; reset = 1'b1;
    tick();
    exp_errs = 0;
    chk("rb_ov0", out_valid, 9'h000);
    chk("rb_data0", out_data, '0);
    chk("rb_cnt0", err_count, 8'h00);
    chk("rb_rdy_rst", in_ready, 1'b0);
    reset = 1'b0; out_ready = 9'h000;
    #1 chk("rb_rdy_idle", in_ready, 1'b1);
    tick();
    chk("rb_abandon", out_valid, 9'h000);

    // counter saturation
    out_ready = 9'h1FF; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_sel = 4'(9 + (i % 6));
      in_data = 16'(i);
      exp_errs++;
      tick();
    end
    chk("sat_cnt", err_count, exp_cnt());
    chk("sat_err", err_pulse, 1'b1);
    chk("sat_ov", out_valid, 9'h000);
    in_valid = 1'b0;
    tick();
    chk("sat_hold", err_count, exp_cnt());
    chk("sat_err_end", err_pulse, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1to9_stream.md
Name: demux1to9_stream

Overview:
- Streaming 1-to-9 demultiplexer: the distribution-side counterpart of the team's 9-input 16-bit select mux.
- Accepts one 16-bit word plus a 4-bit destination select over a valid/ready input. Delivers the word to one of nine registered output lanes.
- Select 15 broadcasts the word to all nine lanes. Selects 9..14 are illegal: the word is dropped and flagged.
- Sits between a single producer and nine independent consumers.

Parameters:
- WIDTH, 16, data width per word/lane
- NOUT, 9, number of output lanes (fixed at 9; SELW must cover NOUT-1 and BCAST_SEL)
- SELW, 4, select width
- BCAST_SEL, 4'hF, select value meaning broadcast
- ERR_CNT_W, 8, error counter width

Ports:
- clk  input  1  single clock, all logic rising-edge
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  SELW  destination lane 0..8, BCAST_SEL=broadcast, else illegal
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts word this cycle (transfer = in_valid & in_ready)
- out_data  output  NOUT*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  NOUT  lane k holds a word
- out_ready  input  NOUT  consumer k takes word (transfer = out_valid[k] & out_ready[k])
- err_pulse  output  1  one-cycle pulse, one cycle after an illegal-select word is accepted
- err_count  output  ERR_CNT_W  saturating count of dropped illegal words

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - out_valid=0, out_data=0, err_pulse=0, err_count=0, state=IDLE, pending mask=0.
  - in_ready=0 while reset is asserted.
  - Reset mid-broadcast abandons the pending lanes.
- Lane register, one per lane:
  - can_load[k] = !out_valid[k] | out_ready[k].
  - On load: out_data[k] <= word, out_valid[k] <= 1.
  - On consumer transfer without load: out_valid[k] <= 0; out_data holds its last value.
  - Latency: input transfer to out_valid = 1 cycle. Full throughput: one word per cycle per lane when the consumer is always ready.
- State IDLE, in_ready by select:
  - sel 0..8: in_ready = can_load[sel] (combinational path through in_sel and out_ready, by design).
  - sel 9..14: in_ready = 1; word discarded, err_pulse next cycle, err_count += 1, saturating at all-ones.
  - sel BCAST_SEL: in_ready = 1.
- Broadcast transfer in IDLE:
  - Every lane with can_load=1 loads this cycle.
  - If all nine load, remain in IDLE.
  - Otherwise: latch word into bcast_buf, set pending = ~can_load, go to BCAST_WAIT.
- State BCAST_WAIT:
  - in_ready = 0.
  - Each cycle, every pending lane with can_load=1 loads bcast_buf and clears its pending bit.
  - When pending becomes 0, return to IDLE; in_ready may assert in the cycle after the last pending load.
- Simultaneous events:
  - Consumer pop and new load on the same lane in the same cycle: the load wins, out_valid stays 1, no bubble.
  - err_pulse for back-to-back illegal words stays high for consecutive cycles, one cycle per word.
- in_valid=0: no state change apart from consumer pops.

Optional Feature:
- DEMUX_ERR_CNT_EN
  - Defined: err_count implemented as above.
  - Undefined: err_count tied to 0, no counter flops; err_pulse and drop behaviour unchanged.

Decomposition:
- Package demux_pkg: WIDTH, NOUT, SELW, BCAST_SEL constants; state enum {IDLE, BCAST_WAIT}; lane-index typedef.
- Sub-module demux_lane_reg: single 1-deep lane register (load, data, valid, ready). Instantiated NOUT times by generate.
- FSM, pending mask and error logic live in the top.

Test Plan:
- Unicast: all out_ready=1; send 16'h1234 sel=3 -> next cycle out_valid=9'b000001000, lane 3 data 16'h1234; other lanes unchanged.
- Backpressure: out_ready[5]=0; send 16'hAAAA then 16'hBBBB to sel=5 -> first accepted; in_ready=0 for the second until out_ready[5]=1, then lane 5 shows 16'hBBBB the cycle after.
- Illegal select: send sel=9, 12, 14 back-to-back -> in_ready=1 each cycle, no out_valid, err_pulse high 3 cycles, err_count=3 (0 without DEMUX_ERR_CNT_EN).
- Broadcast partial: lanes 2 and 7 full with out_ready=0; send 16'hCAFE sel=15 -> other seven lanes load next cycle, in_ready=0; release lane 2 then lane 7 -> each loads 16'hCAFE in turn; in_ready returns after lane 7 loads.
- Saturation: with DEMUX_ERR_CNT_EN, send 300 illegal words -> err_count=8'hFF, holds.
- Reset mid-broadcast: assert reset during BCAST_WAIT -> next cycle out_valid=0, state=IDLE, err_count=0; in_ready=1 after reset deasserts, given sel=15.
